// File: rtl/uart_loop_buffer_if.sv
// Handshake bundle between the receive side, the loop buffer and the transmitter.
// The buffer uses the slave modport; whatever drives the receive/transmit side uses master.
interface uart_loop_buffer_if #(
    parameter int ADDR_W = 4
);
    logic            in_valid;
    logic [7:0]      in_data;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_done;
    logic [ADDR_W:0] count;
    logic            empty;
    logic            full;
    logic            overflow;
    logic [7:0]      drop_cnt;

    modport master (
        output in_valid, in_data, tx_done,
        input  tx_start, tx_data, count, empty, full, overflow, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, tx_done,
        output tx_start, tx_data, count, empty, full, overflow, drop_cnt
    );
endinterface

// File: rtl/uart_loop_buffer.sv
// Byte FIFO between the UART receiver and transmitter, issuing one frame at a time
// and waiting for the transmitter's completion pulse before issuing the next.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no frame in flight; pops the head byte when the FIFO is not empty
// START     | tx_start is high for this single cycle; tx_data holds the popped byte
// WAIT_DONE | frame in flight; returns to IDLE on tx_done
module uart_loop_buffer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    uart_loop_buffer_if.slave bus_if
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic [ADDR_W:0] count;
    logic            empty;
    logic            full;
    logic            pop;
    logic            wr_en;
    logic            drop;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A pop in the same cycle frees a slot, so a full FIFO can still take a byte.
    assign pop   = (state_q == IDLE) && !empty;
    assign wr_en = bus_if.in_valid && (!full || pop);
    assign drop  = bus_if.in_valid && full && !pop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!empty) state_d = START;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: if (bus_if.tx_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            tx_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= (state_d == START);
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset; pointers define which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus_if.in_data;
        end
    end

    assign bus_if.tx_start = tx_start_q;
    assign bus_if.tx_data  = tx_data_q;
    assign bus_if.count    = count;
    assign bus_if.empty    = empty;
    assign bus_if.full     = full;
    assign bus_if.overflow = overflow_q;
    assign bus_if.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_uart_loop_buffer.sv
// Scoreboard bench for uart_loop_buffer: a queue-level reference model predicts every
// frame issue and status value; a negedge monitor compares the DUT against it.
module tb_uart_loop_buffer;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_loop_buffer_if #(.ADDR_W(ADDR_W)) bus_if ();
    uart_loop_buffer #(.ADDR_W(ADDR_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_if(bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int         cyc = 0;
    logic [7:0] mq[$];
    bit         outstanding = 0;
    int         pop_edge = 0;
    bit         m_ovf = 0;
    int         m_drop = 0;
    logic [7:0] m_last_tx = 8'h00;
    exp_t       exp_q[$];

    // transmitter emulation
    bit mon_on     = 0;
    bit auto_done  = 1;
    int done_delay = 10;
    int done_cd    = 0;
    int manual_req = 0;
    int manual_ack = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference model: a byte queue plus "one frame outstanding from pop until its done".
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            outstanding = 0;
            m_ovf       = 0;
            m_drop      = 0;
            m_last_tx   = 8'h00;
        end else begin
            bit   do_pop;
            exp_t e;
            do_pop = !outstanding && (mq.size() > 0);
            if (do_pop) begin
                m_last_tx   = mq.pop_front();
                e.data      = m_last_tx;
                e.cyc       = cyc;
                exp_q.push_back(e);
                outstanding = 1;
                pop_edge    = cyc;
            end else if (outstanding && bus_if.tx_done && (cyc > pop_edge + 1)) begin
                outstanding = 0;
            end
            if (bus_if.in_valid) begin
                if (mq.size() < DEPTH) mq.push_back(bus_if.in_data);
                else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    end

    // Monitor: every tx_start must match the head of the expected-frame queue.
    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            if (bus_if.tx_start) begin
                chk("tx_start_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tx_data_at_start", bus_if.tx_data, e.data);
                    chk("tx_start_cycle", cyc, e.cyc);
                end
                if (auto_done) done_cd = done_delay;
            end
            chk("count", bus_if.count, mq.size());
            chk("empty", bus_if.empty, int'(mq.size() == 0));
            chk("full", bus_if.full, int'(mq.size() == DEPTH));
            chk("overflow", bus_if.overflow, m_ovf);
            chk("drop_cnt", bus_if.drop_cnt, m_drop);
            chk("tx_data_hold", bus_if.tx_data, m_last_tx);
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        bus_if.tx_done = 1'b0;
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) bus_if.tx_done = 1'b1;
        end
        if (manual_req != manual_ack) begin
            manual_ack     = manual_req;
            bus_if.tx_done = 1'b1;
        end
    end

    task automatic drive(input bit v, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus_if.in_valid = v;
        bus_if.in_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((mq.size() > 0 || outstanding) && n < 3000) begin
            drive(1'b0, 8'h00);
            n++;
        end
        chk(name, int'(mq.size() > 0 || outstanding), 0);
        idle(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        bus_if.tx_done  = 1'b0;

        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1;
        chk("reset_count", bus_if.count, 0);
        chk("reset_empty", bus_if.empty, 1);
        chk("reset_full", bus_if.full, 0);
        chk("reset_tx_start", bus_if.tx_start, 0);
        chk("reset_tx_data", bus_if.tx_data, 0);

        // single byte
        done_delay = 10;
        drive(1'b1, 8'hA5);
        wait_drain("single_drain");

        // burst ordering
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i));
        wait_drain("burst_drain");
        chk("burst_empty", bus_if.empty, 1);

        // overflow: no completions, 18 bytes
        auto_done = 0;
        for (int i = 0; i < 18; i++) drive(1'b1, 8'(8'h40 + i));
        idle(2);
        chk("ovf_full", bus_if.full, 1);
        chk("ovf_count", bus_if.count, 16);
        chk("ovf_flag", bus_if.overflow, 1);
        chk("ovf_drop_cnt", bus_if.drop_cnt, 1);

        // full FIFO, byte arrives in the pop cycle
        manual_req++;
        auto_done = 1;
        done_delay = 2;
        drive(1'b1, 8'h99);
        drive(1'b0, 8'h00);
        chk("fullpop_count", bus_if.count, 16);
        chk("fullpop_drop_cnt", bus_if.drop_cnt, 1);
        wait_drain("fullpop_drain");

        // wrap-around stream
        for (int i = 0; i < 40; i++) begin
            done_delay = $urandom_range(1, 2);
            drive(1'b1, 8'(i));
            idle($urandom_range(3, 7));
        end
        wait_drain("wrap_drain");

        // random traffic, including bursts that overflow
        for (int i = 0; i < 300; i++) begin
            done_delay = $urandom_range(1, 6);
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        wait_drain("random_drain");

        // reset mid-frame with bytes queued
        done_delay = 10;
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hB0 + i));
        idle(3);
        @(posedge clk);
        #1 rst = 1'b1;
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mid_count", bus_if.count, 0);
        chk("rst_mid_tx_start", bus_if.tx_start, 0);
        chk("rst_mid_overflow", bus_if.overflow, 0);
        idle(15);
        drive(1'b1, 8'h3C);
        wait_drain("post_reset_drain");

        chk("expected_frames_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_loop_buffer.md
# uart_loop_buffer

Byte buffer and transmit sequencer between the receiver's output (`rx_data`/`rx_finish`) and the transmitter's input. It sits on the divided `clk` domain. Received bytes are queued in a power-of-two FIFO and issued to the transmitter one frame at a time. Each frame is issued with a start pulse, and the next frame is not issued until the transmitter reports completion. This removes byte loss when bytes arrive back-to-back while a transmission is still in progress.

## Interface
- `ADDR_W`, default 4: FIFO address width; depth = 2^ADDR_W entries.
- `clk` input 1: single clock (the divided baud clock); all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: one-cycle strobe; `in_data` is valid (connects to `rx_finish`).
- `in_data` input 8: received byte.
- `tx_start` output 1: one-cycle pulse; transmitter loads `tx_data` and begins a frame.
- `tx_data` output 8: byte for the transmitter; held stable from the `tx_start` cycle until the next pop.
- `tx_done` input 1: one-cycle pulse from the transmitter at frame end (`tx_finish`).
- `count` output ADDR_W+1: number of bytes currently queued, excluding the byte in flight.
- `empty` output 1: `count == 0`.
- `full` output 1: `count == 2^ADDR_W`.
- `overflow` output 1: sticky flag; a byte was dropped.
- `drop_cnt` output 8: saturating count of dropped bytes.

## Operation
**Storage**
- Storage: `mem[2^ADDR_W]`, 8 bits wide.
- Pointers: `wr_ptr`/`rd_ptr`, ADDR_W+1 bits each, wrapping modulo 2^(ADDR_W+1).
- `count = wr_ptr - rd_ptr`.

**Write path**
- Write occurs if `in_valid && (!full || pop)`: `mem[wr_ptr[ADDR_W-1:0]] <= in_data`, `wr_ptr++`.
- Drop occurs if `in_valid && full && !pop`:
  - `overflow <= 1`, which holds until `rst`.
  - `drop_cnt++`, saturating at 255.
  - Pointers are unchanged.

**Pop**
- `pop = (state == IDLE) && !empty`.
- On pop: `tx_data <= mem[rd_ptr[ADDR_W-1:0]]`, `rd_ptr++`.
- Write and pop in the same cycle are both performed; `count` is unchanged.

**FSM states**
- IDLE: if `!empty`, pop and go to START; otherwise stay in IDLE.
- START: `tx_start = 1` for exactly this cycle; go to WAIT unconditionally.
- WAIT: stay until `tx_done = 1`, then go to IDLE.
- `tx_done` is ignored in IDLE and START and has no side effect there.
- Unreachable state encodings return to IDLE on the next cycle.

**Outputs**
- `tx_start` is registered: `tx_start = (state == START)`.
- `empty`, `full` and `count` are derived from the registered pointers.

**Reset (`rst = 1` at an edge)**
- state = IDLE, both pointers 0, `tx_data = 0`, `tx_start = 0`.
- `overflow = 0`, `drop_cnt = 0`, `count = 0`, `empty = 1`, `full = 0`.
- Reset mid-frame abandons the queued bytes and the in-flight byte. No `tx_start` is issued during the reset cycle or the cycle after it.
- `in_valid` is ignored while `rst = 1`.

## Timing
- `in_valid` at edge N with an empty FIFO in IDLE:
  - `count = 1` after edge N.
  - Pop at edge N+1.
  - `tx_start = 1` and `tx_data` valid during cycle N+1..N+2 (two-edge latency).
- `tx_done` at edge M with `count > 0`: IDLE after M, pop at M+1, next `tx_start` during cycle M+1..M+2.
- Minimum spacing between `tx_start` pulses is 3 cycles (START, WAIT with `tx_done`, IDLE).
- Throughput is limited only by the transmitter; the buffer adds 2 cycles of gap per frame.
- `count` counts queued bytes only. A full FIFO plus the byte in flight holds 2^ADDR_W+1 bytes in total.
- `full`/`empty` change one edge after the causing write or pop.

## Test plan
- **Single byte:** reset, then `in_valid` with `0xA5` → `tx_start` one cycle, 2 edges later, with `tx_data = 0xA5`; `count` goes 1→0; no further `tx_start` until another `in_valid`.
- **Burst ordering:** 5 bytes `0x01..0x05` on consecutive cycles, `tx_done` returned 10 cycles after each `tx_start` → exactly 5 `tx_start` pulses, in order `0x01..0x05`, each 2 edges after the preceding `tx_done`; `empty = 1` at the end.
- **Overflow (`ADDR_W = 4`):** hold `tx_done` low and send 18 bytes → 1 in flight, 16 queued (`full = 1`, `count = 16`), 1 dropped; `overflow = 1`, `drop_cnt = 1`; the dropped byte is the 18th.
- **Full with simultaneous pop:** FIFO full in IDLE (pulse `tx_done` after 17 writes), `in_valid` in the pop cycle → byte accepted, `count` stays 16, `drop_cnt` unchanged.
- **Wrap-around:** stream 40 bytes `0x00..0x27` with prompt `tx_done` → all 40 transmitted in order; pointers wrap with no corruption.
- **Reset mid-operation:** 3 bytes queued in WAIT, assert `rst` one cycle → `count = 0`, `tx_start = 0`, `overflow = 0`; a later `tx_done` causes no `tx_start`; a new byte `0x3C` is sent normally.
